// File: rtl/trn_adc_axil_pkg.sv
// ============================================================================
// Module      : trn_adc_axil_pkg
// Description : Shared constants, FSM state types and address-decode helpers
//               for the TRN ADC AXI4-Lite register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trn_adc_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        STAT    = 3'd1,
        IRQ_ST  = 3'd2,
        IRQ_EN  = 3'd3,
        INVALID = 3'd4
    } reg_kind_t;

    // Byte address -> word index. Bits above the bus address width and the
    // byte-lane bits are discarded.
    function automatic int unsigned word_index(input logic [31:0]  addr,
                                               input int unsigned  addr_width,
                                               input int unsigned  data_width);
        logic [31:0] masked;
        int unsigned lsb;
        lsb    = (data_width == 32'd64) ? 32'd3 : 32'd2;
        masked = (addr_width >= 32'd32) ? addr
                                        : (addr & ((32'd1 << addr_width) - 32'd1));
        return masked >> lsb;
    endfunction

    // Classify a word index: control block, status block, the two optional
    // interrupt registers, or nothing at all.
    function automatic reg_kind_t decode_kind(input int unsigned idx,
                                              input int unsigned n_ctrl,
                                              input int unsigned n_stat,
                                              input logic        irq_present);
        if (idx < n_ctrl)
            return CTRL;
        else if (idx < n_ctrl + n_stat)
            return STAT;
        else if (irq_present && (idx == n_ctrl + n_stat))
            return IRQ_ST;
        else if (irq_present && (idx == n_ctrl + n_stat + 32'd1))
            return IRQ_EN;
        else
            return INVALID;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trn_adc_axil_wstrb_merge.sv
// ============================================================================
// Module      : trn_adc_axil_wstrb_merge
// Description : Combinational byte merge: each output byte takes the new data
//               where its strobe bit is set, otherwise keeps the old data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trn_adc_axil_wstrb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   i_old_data,
    input  logic [DATA_WIDTH-1:0]   i_new_data,
    input  logic [DATA_WIDTH/8-1:0] i_strb,
    output logic [DATA_WIDTH-1:0]   o_merged
);

    generate
        for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_byte
            assign o_merged[b*8 +: 8] = i_strb[b] ? i_new_data[b*8 +: 8]
                                                  : i_old_data[b*8 +: 8];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/trn_adc_axil_regbank.sv
// ============================================================================
// Module      : trn_adc_axil_regbank
// Description : Parametrised AXI4-Lite slave register bank: R/W control
//               registers, RO status registers sampled from the ADC core,
//               byte-strobe writes and SLVERR decode.
//               Optional interrupt block enabled by macro TRN_ADC_AXIL_IRQ_EN
//               (IRQ_STATUS W1C + IRQ_ENABLE after the status block).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trn_adc_axil_regbank
    import trn_adc_axil_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    NUM_CTRL_REGS  = 4,
    parameter int                    NUM_STAT_REGS  = 4,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET_VAL = '0
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_CTRL_REGS*DATA_WIDTH-1:0] ctrl_o,
    input  logic [NUM_STAT_REGS*DATA_WIDTH-1:0] stat_i,
    input  logic [DATA_WIDTH-1:0]             irq_event_i,
    output logic                              irq_o
);

`ifdef TRN_ADC_AXIL_IRQ_EN
    localparam logic c_irq_present = 1'b1;
`else
    localparam logic c_irq_present = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                      r_live;
    wr_state_t                 r_wstate;
    wr_state_t                 w_wstate_next;
    rd_state_t                 r_rstate;
    rd_state_t                 w_rstate_next;

    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    logic [1:0]                r_bresp;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                r_rresp;

    logic [DATA_WIDTH-1:0]     r_ctrl [NUM_CTRL_REGS];

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_ar_hs;
    logic                      w_commit;

    logic [ADDR_WIDTH-1:0]     w_wr_addr;
    logic [DATA_WIDTH-1:0]     w_wr_data;
    logic [DATA_WIDTH/8-1:0]   w_wr_strb;
    int unsigned               w_wr_idx;
    reg_kind_t                 w_wr_kind;
    logic [DATA_WIDTH-1:0]     w_wr_old;
    logic [DATA_WIDTH-1:0]     w_wr_merged;

    int unsigned               w_rd_idx;
    reg_kind_t                 w_rd_kind;
    logic [DATA_WIDTH-1:0]     w_rd_data;
    logic [1:0]                w_rd_resp;

`ifdef TRN_ADC_AXIL_IRQ_EN
    logic [DATA_WIDTH-1:0]     r_irq_status;
    logic [DATA_WIDTH-1:0]     r_irq_en;
    logic                      r_irq;
    logic [DATA_WIDTH-1:0]     w_irq_clr;
    logic [DATA_WIDTH-1:0]     w_irq_wr_mask;
`endif

    // ------------------------------------------------------------------
    // Handshakes. READY stays low through reset and for the release edge.
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = r_live && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_W));
    assign S_AXI_WREADY  = r_live && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW));
    assign S_AXI_ARREADY = r_live && (r_rstate == R_IDLE);
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_RVALID  = (r_rstate == R_RESP);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    assign w_aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Marks the bank live one edge after reset release.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    // Whichever half arrived earlier comes from its latch; the other is live.
    assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : S_AXI_AWADDR;
    assign w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata  : S_AXI_WDATA;
    assign w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : S_AXI_WSTRB;
    assign w_wr_idx  = word_index(32'(w_wr_addr), ADDR_WIDTH, DATA_WIDTH);
    assign w_wr_kind = decode_kind(w_wr_idx, NUM_CTRL_REGS, NUM_STAT_REGS, c_irq_present);

    // Write FSM next state; commit fires on the edge both halves are held.
    always_comb begin
        w_wstate_next = r_wstate;
        w_commit      = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end else if (w_aw_hs) begin
                    w_wstate_next = W_HAVE_AW;
                end else if (w_w_hs) begin
                    w_wstate_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_w_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (w_aw_hs) begin
                    w_commit      = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    // Write FSM state, address/data latches and the response code.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
            if (w_w_hs) begin
                r_wdata <= S_AXI_WDATA;
                r_wstrb <= S_AXI_WSTRB;
            end
            if (w_commit) begin
                r_bresp <= ((w_wr_kind == CTRL) || (w_wr_kind == IRQ_ST) || (w_wr_kind == IRQ_EN))
                           ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Current contents of the writable register being targeted.
    always_comb begin
        w_wr_old = '0;
        for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
            if (w_wr_idx == k) w_wr_old = r_ctrl[k];
        end
`ifdef TRN_ADC_AXIL_IRQ_EN
        if (w_wr_kind == IRQ_EN) w_wr_old = r_irq_en;
`endif
    end

    trn_adc_axil_wstrb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_merge (
        .i_old_data (w_wr_old),
        .i_new_data (w_wr_data),
        .i_strb     (w_wr_strb),
        .o_merged   (w_wr_merged)
    );

    // Control register file.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) r_ctrl[k] <= CTRL_RESET_VAL;
        end else if (w_commit && (w_wr_kind == CTRL)) begin
            for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
                if (w_wr_idx == k) r_ctrl[k] <= w_wr_merged;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CTRL_REGS; k++) begin : g_ctrl_out
            assign ctrl_o[k*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign w_rd_idx  = word_index(32'(S_AXI_ARADDR), ADDR_WIDTH, DATA_WIDTH);
    assign w_rd_kind = decode_kind(w_rd_idx, NUM_CTRL_REGS, NUM_STAT_REGS, c_irq_present);

    // Read mux; register values are pre-write on a same-edge write.
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        case (w_rd_kind)
            CTRL: begin
                w_rd_resp = RESP_OKAY;
                for (int unsigned k = 0; k < NUM_CTRL_REGS; k++) begin
                    if (w_rd_idx == k) w_rd_data = r_ctrl[k];
                end
            end
            STAT: begin
                w_rd_resp = RESP_OKAY;
                for (int unsigned k = 0; k < NUM_STAT_REGS; k++) begin
                    if (w_rd_idx == NUM_CTRL_REGS + k) w_rd_data = stat_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`ifdef TRN_ADC_AXIL_IRQ_EN
            IRQ_ST: begin
                w_rd_resp = RESP_OKAY;
                w_rd_data = r_irq_status;
            end
            IRQ_EN: begin
                w_rd_resp = RESP_OKAY;
                w_rd_data = r_irq_en;
            end
`endif
            default: begin
                w_rd_data = '0;
                w_rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // Read FSM next state.
    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)      w_rstate_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // Read FSM state; data/response captured on the AR handshake and held.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupt block
    // ------------------------------------------------------------------
`ifdef TRN_ADC_AXIL_IRQ_EN
    // Strobe-qualified write data doubles as the W1C clear mask.
    trn_adc_axil_wstrb_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_irq_clr_merge (
        .i_old_data ({DATA_WIDTH{1'b0}}),
        .i_new_data (w_wr_data),
        .i_strb     (w_wr_strb),
        .o_merged   (w_irq_wr_mask)
    );

    assign w_irq_clr = (w_commit && (w_wr_kind == IRQ_ST)) ? w_irq_wr_mask : '0;

    // Sticky status (new events beat a same-edge clear), enable, and output.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_irq_status <= '0;
            r_irq_en     <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_irq_status <= (r_irq_status & ~w_irq_clr) | irq_event_i;
            if (w_commit && (w_wr_kind == IRQ_EN)) r_irq_en <= w_wr_merged;
            r_irq        <= |(r_irq_status & r_irq_en);
        end
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq_event;
    assign w_unused_irq_event = ^irq_event_i;
    assign irq_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trn_adc_axil_regbank.sv
// ============================================================================
// Module      : tb_trn_adc_axil_regbank
// Description : Self-checking bench for trn_adc_axil_regbank. Expected B and R
//               responses are queued when a transaction is issued and checked
//               by channel monitors when the DUT completes it.
//               Interrupt tests follow macro TRN_ADC_AXIL_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trn_adc_axil_regbank;
    import trn_adc_axil_pkg::*;

    logic          ACLK;
    logic          ARESET;
    logic [7:0]    S_AXI_AWADDR;
    logic          S_AXI_AWVALID;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic          S_AXI_WVALID;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY;
    logic [7:0]    S_AXI_ARADDR;
    logic          S_AXI_ARVALID;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY;
    logic [127:0]  ctrl_o;
    logic [127:0]  stat_i;
    logic [31:0]   irq_event_i;
    logic          irq_o;

    int            n_checks;
    int            n_errors;
    logic [1:0]    b_exp_q [$];
    logic [33:0]   r_exp_q [$];

    trn_adc_axil_regbank dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ctrl_o        (ctrl_o),
        .stat_i        (stat_i),
        .irq_event_i   (irq_event_i),
        .irq_o         (irq_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] exp_resp);
        int   t = 0;
        logic aw_hs;
        logic w_hs;
        b_exp_q.push_back(exp_resp);
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && t < 50) begin
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            t++;
        end
        if (S_AXI_AWVALID || S_AXI_WVALID) begin
            check("wr_handshake_timeout", {S_AXI_AWVALID, S_AXI_WVALID}, 2'b00);
            S_AXI_AWVALID = 1'b0;
            S_AXI_WVALID  = 1'b0;
        end
    endtask

    task automatic rd(input logic [7:0] addr, input logic [1:0] exp_resp, input logic [31:0] exp_data);
        int   t = 0;
        logic ar_hs;
        r_exp_q.push_back({exp_resp, exp_data});
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        while (S_AXI_ARVALID && t < 50) begin
            @(negedge ACLK);
            ar_hs = S_AXI_ARREADY;
            tick();
            if (ar_hs) S_AXI_ARVALID = 1'b0;
            t++;
        end
        if (S_AXI_ARVALID) begin
            check("rd_handshake_timeout", S_AXI_ARVALID, 1'b0);
            S_AXI_ARVALID = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        tick();
        while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && t < 100) begin
            tick();
            t++;
        end
        check("queues_drained", b_exp_q.size() + r_exp_q.size(), 0);
    endtask

    // B-channel scoreboard
    initial begin
        forever begin
            @(negedge ACLK);
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (b_exp_q.size() == 0) check("b_unexpected", S_AXI_BVALID, 1'b0);
                else                     check("bresp", S_AXI_BRESP, b_exp_q.pop_front());
            end
        end
    end

    // R-channel scoreboard
    initial begin
        forever begin
            @(negedge ACLK);
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (r_exp_q.size() == 0) check("r_unexpected", S_AXI_RVALID, 1'b0);
                else                     check("rresp_rdata", {S_AXI_RRESP, S_AXI_RDATA}, r_exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        stat_i        = '0;
        irq_event_i   = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_ready_valid",
              {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        check("rst_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
        check("rst_ctrl_o", ctrl_o, 128'h0);
        check("rst_irq_o", irq_o, 1'b0);
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        check("release_ready_low", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        tick();
        check("release_ready_high", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Full-word writes and readback
        for (int i = 0; i < 4; i++) wr(8'(i * 4), 32'(i + 1), 4'hF, RESP_OKAY);
        for (int i = 0; i < 4; i++) rd(8'(i * 4), RESP_OKAY, 32'(i + 1));
        drain();
        check("ctrl_o_words", ctrl_o, {32'h4, 32'h3, 32'h2, 32'h1});

        // Byte strobes
        wr(8'h00, 32'h1122_3344, 4'hF, RESP_OKAY);
        wr(8'h00, 32'hAABB_CCDD, 4'h5, RESP_OKAY);
        rd(8'h00, RESP_OKAY, 32'h11BB_33DD);
        drain();
        check("ctrl_o_strb", ctrl_o[31:0], 32'h11BB_33DD);

        // W three cycles ahead of AW
        b_exp_q.push_back(RESP_OKAY);
        S_AXI_WDATA  = 32'h0000_0055;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        @(negedge ACLK);
        check("wfirst_wready", S_AXI_WREADY, 1'b1);
        tick();
        S_AXI_WVALID = 1'b0;
        @(negedge ACLK);
        check("wfirst_have_w", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
        tick();
        tick();
        S_AXI_AWADDR  = 8'h04;
        S_AXI_AWVALID = 1'b1;
        @(negedge ACLK);
        check("wfirst_pre_bvalid", {S_AXI_AWREADY, S_AXI_BVALID}, 2'b10);
        tick();
        S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid", S_AXI_BVALID, 1'b1);
        drain();

        // AW and W in the same cycle
        wr(8'h0C, 32'h0000_0066, 4'hF, RESP_OKAY);
        check("same_cycle_bvalid", S_AXI_BVALID, 1'b1);
        rd(8'h04, RESP_OKAY, 32'h0000_0055);
        rd(8'h0C, RESP_OKAY, 32'h0000_0066);
        drain();

        // Read and write of one control register on the same edge
        fork
            wr(8'h08, 32'h0000_0077, 4'hF, RESP_OKAY);
            rd(8'h08, RESP_OKAY, 32'h0000_0003);
        join
        rd(8'h08, RESP_OKAY, 32'h0000_0077);
        drain();

        // Status block and out-of-range decode
        stat_i[31:0]  = 32'hDEAD_BEEF;
        stat_i[63:32] = 32'h0BAD_F00D;
        rd(8'h10, RESP_OKAY, 32'hDEAD_BEEF);
        rd(8'h14, RESP_OKAY, 32'h0BAD_F00D);
        wr(8'h10, 32'h1234_5678, 4'hF, RESP_SLVERR);
        rd(8'h10, RESP_OKAY, 32'hDEAD_BEEF);
        rd(8'h40, RESP_SLVERR, 32'h0);
        wr(8'h40, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        drain();
        check("ctrl_o_after_slverr", ctrl_o, {32'h66, 32'h77, 32'h55, 32'h11BB_33DD});

        // Back-pressure on B
        S_AXI_BREADY = 1'b0;
        wr(8'h08, 32'h0000_00A5, 4'hF, RESP_OKAY);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("b_stall", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}, 5'b1_00_0_0);
            tick();
        end
        S_AXI_BREADY = 1'b1;
        drain();

        // Back-pressure on R; status changes after AR must not leak through
        S_AXI_RREADY = 1'b0;
        rd(8'h10, RESP_OKAY, 32'hDEAD_BEEF);
        stat_i[31:0] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("r_stall", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                  {1'b1, 1'b0, 2'b00, 32'hDEAD_BEEF});
            tick();
        end
        S_AXI_RREADY = 1'b1;
        rd(8'h08, RESP_OKAY, 32'h0000_00A5);
        drain();

`ifdef TRN_ADC_AXIL_IRQ_EN
        irq_event_i = 32'h1;
        tick();
        irq_event_i = 32'h0;
        rd(8'h20, RESP_OKAY, 32'h1);
        wr(8'h24, 32'h1, 4'hF, RESP_OKAY);
        tick();
        check("irq_asserted", irq_o, 1'b1);
        tick();
        // Clear and new event on the same edge: event wins
        b_exp_q.push_back(RESP_OKAY);
        S_AXI_AWADDR  = 8'h20;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = 32'h1;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b1;
        irq_event_i   = 32'h1;
        @(negedge ACLK);
        check("irq_clr_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        irq_event_i   = 32'h0;
        rd(8'h20, RESP_OKAY, 32'h1);
        drain();
        check("irq_kept", irq_o, 1'b1);
        wr(8'h20, 32'h1, 4'hF, RESP_OKAY);
        check("irq_one_cycle_late", irq_o, 1'b1);
        tick();
        check("irq_cleared", irq_o, 1'b0);
        rd(8'h20, RESP_OKAY, 32'h0);
        rd(8'h24, RESP_OKAY, 32'h1);
        drain();
`else
        irq_event_i = 32'hFFFF_FFFF;
        tick();
        irq_event_i = 32'h0;
        rd(8'h20, RESP_SLVERR, 32'h0);
        wr(8'h24, 32'h1, 4'hF, RESP_SLVERR);
        rd(8'h24, RESP_SLVERR, 32'h0);
        drain();
        check("irq_disabled", irq_o, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
